// File: rtl/retire_write_scheduler.sv
// In-order retire queue feeding 3 registered register-file write ports with tagged busy-clear.
// Optional RETIRE_WR_COALESCE_EN: suppress older same-target writes within one drain group.
module retire_write_scheduler #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int TAG_W  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [2:0]                  enq_valid_i,
  input  logic [2:0][REG_W-1:0]       enq_reg_i,
  input  logic [2:0][DATA_W-1:0]      enq_data_i,
  input  logic [2:0][TAG_W-1:0]       enq_tag_i,
  output logic                        enq_ready_o,
  input  logic                        wr_stall_i,
  input  logic                        flush_i,
  output logic [2:0]                  wr_en_o,
  output logic [2:0][REG_W-1:0]       wr_reg_o,
  output logic [2:0][DATA_W-1:0]      wr_data_o,
  output logic [2:0]                  clr_en_o,
  output logic [2:0][REG_W-1:0]       clr_reg_o,
  output logic [2:0][TAG_W-1:0]       clr_tag_o,
  output logic [CW-1:0]               occupancy_o
);

  logic [DEPTH-1:0][REG_W-1:0]  mem_reg_q;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data_q;
  logic [DEPTH-1:0][TAG_W-1:0]  mem_tag_q;

  logic [AW-1:0]           head_q, tail_q;
  logic [CW-1:0]           occ_q;
  logic [2:0]              wr_en_q, clr_en_q;
  logic [2:0][REG_W-1:0]   wr_reg_q;
  logic [2:0][DATA_W-1:0]  wr_data_q;
  logic [2:0][TAG_W-1:0]   clr_tag_q;

  logic                    enq_fire;
  logic [1:0]              enq_cnt, drain_n;
  logic [2:0][1:0]         slot_off;
  logic [2:0][AW-1:0]      rd_idx;
  logic [2:0]              drain_vec, wr_en_d;

  always_comb begin
    enq_ready_o = (CW'(DEPTH) - occ_q) >= CW'(3);
    enq_fire    = enq_ready_o & (|enq_valid_i) & ~flush_i;
    enq_cnt     = 2'(enq_valid_i[0]) + 2'(enq_valid_i[1]) + 2'(enq_valid_i[2]);
    // Valid slots pack densely at tail in slot order.
    slot_off[0] = 2'd0;
    slot_off[1] = 2'(enq_valid_i[0]);
    slot_off[2] = 2'(enq_valid_i[0]) + 2'(enq_valid_i[1]);

    if (wr_stall_i || flush_i) drain_n = 2'd0;
    else if (occ_q >= CW'(3))  drain_n = 2'd3;
    else                       drain_n = occ_q[1:0];

    case (drain_n)
      2'd3:    drain_vec = 3'b111;
      2'd2:    drain_vec = 3'b011;
      2'd1:    drain_vec = 3'b001;
      default: drain_vec = 3'b000;
    endcase

    for (int k = 0; k < 3; k++) rd_idx[k] = head_q + AW'(k);

    wr_en_d = drain_vec;
`ifdef RETIRE_WR_COALESCE_EN
    for (int k = 0; k < 2; k++)
      for (int j = k + 1; j < 3; j++)
        if (drain_vec[j] && mem_reg_q[rd_idx[j]] == mem_reg_q[rd_idx[k]])
          wr_en_d[k] = 1'b0;
`endif
  end

  // Queue storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      for (int s = 0; s < 3; s++) begin
        if (enq_valid_i[s]) begin
          mem_reg_q [tail_q + AW'(slot_off[s])] <= enq_reg_i[s];
          mem_data_q[tail_q + AW'(slot_off[s])] <= enq_data_i[s];
          mem_tag_q [tail_q + AW'(slot_off[s])] <= enq_tag_i[s];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
      wr_en_q   <= '0;
      clr_en_q  <= '0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      clr_tag_q <= '0;
    end else if (flush_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      wr_en_q  <= '0;
      clr_en_q <= '0;
    end else begin
      head_q   <= head_q + AW'(drain_n);
      tail_q   <= tail_q + (enq_fire ? AW'(enq_cnt) : AW'(0));
      occ_q    <= occ_q + (enq_fire ? CW'(enq_cnt) : CW'(0)) - CW'(drain_n);
      wr_en_q  <= wr_en_d;
      clr_en_q <= drain_vec;
      for (int k = 0; k < 3; k++) begin
        if (drain_vec[k]) begin
          wr_reg_q[k]  <= mem_reg_q[rd_idx[k]];
          wr_data_q[k] <= mem_data_q[rd_idx[k]];
          clr_tag_q[k] <= mem_tag_q[rd_idx[k]];
        end
      end
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_reg_o    = wr_reg_q;
  assign wr_data_o   = wr_data_q;
  assign clr_en_o    = clr_en_q;
  assign clr_reg_o   = wr_reg_q;
  assign clr_tag_o   = clr_tag_q;
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_retire_write_scheduler.sv
// Directed + short random bench for retire_write_scheduler with an in-order expected-write scoreboard.
module tb_retire_write_scheduler;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
    logic [3:0]  t;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       enq_valid;
  logic [2:0][3:0]  enq_reg;
  logic [2:0][15:0] enq_data;
  logic [2:0][3:0]  enq_tag;
  logic             enq_ready;
  logic             wr_stall, flush;
  logic [2:0]       wr_en, clr_en;
  logic [2:0][3:0]  wr_reg, clr_reg, clr_tag;
  logic [2:0][15:0] wr_data;
  logic [3:0]       occupancy;

  int   n_chk = 0;
  int   n_fail = 0;
  int   m_occ = 0;
  ent_t sb[$];

  always #5 clk = ~clk;

  retire_write_scheduler #(.DEPTH(DEPTH), .DATA_W(16), .REG_W(4), .TAG_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .enq_valid_i(enq_valid), .enq_reg_i(enq_reg), .enq_data_i(enq_data), .enq_tag_i(enq_tag),
    .enq_ready_o(enq_ready), .wr_stall_i(wr_stall), .flush_i(flush),
    .wr_en_o(wr_en), .wr_reg_o(wr_reg), .wr_data_o(wr_data),
    .clr_en_o(clr_en), .clr_reg_o(clr_reg), .clr_tag_o(clr_tag),
    .occupancy_o(occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int s, input logic [3:0] r, input logic [15:0] d, input logic [3:0] t);
    enq_reg[s] = r; enq_data[s] = d; enq_tag[s] = t;
  endtask

  task automatic fill_slots(input logic [15:0] base);
    for (int s = 0; s < 3; s++) set_slot(s, 4'(base + 16'(s)), base + 16'(s), 4'(base + 16'(s) + 16'd5));
  endtask

  // One clock: drive inputs, update the model, then check the registered ports.
  task automatic tick(input logic stall, input logic fl, input logic [2:0] v);
    logic rdy;
    int   n;
    ent_t grp[3];
    logic [2:0] exp_clr, exp_wr;
    wr_stall = stall; flush = fl; enq_valid = v;
    #0;
    rdy = (m_occ <= DEPTH - 3);
    chk("enq_ready", 32'(enq_ready), 32'(rdy));
    n = (stall || fl) ? 0 : (m_occ < 3 ? m_occ : 3);
    for (int k = 0; k < n; k++) grp[k] = sb.pop_front();
    if (fl) begin
      sb.delete();
      m_occ = 0;
    end else begin
      if (rdy && v != 3'b000)
        for (int s = 0; s < 3; s++)
          if (v[s]) begin
            sb.push_back('{r: enq_reg[s], d: enq_data[s], t: enq_tag[s]});
            m_occ++;
          end
      m_occ -= n;
    end
    exp_clr = '0;
    for (int k = 0; k < n; k++) exp_clr[k] = 1'b1;
    exp_wr = exp_clr;
`ifdef RETIRE_WR_COALESCE_EN
    for (int k = 0; k < n; k++)
      for (int j = k + 1; j < n; j++)
        if (grp[j].r == grp[k].r) exp_wr[k] = 1'b0;
`endif
    @(posedge clk);
    #1;
    enq_valid = '0; flush = 1'b0; wr_stall = 1'b0;
    chk("clr_en", 32'(clr_en), 32'(exp_clr));
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    for (int k = 0; k < n; k++) begin
      chk($sformatf("wr_reg[%0d]", k), 32'(wr_reg[k]), 32'(grp[k].r));
      chk($sformatf("wr_data[%0d]", k), 32'(wr_data[k]), 32'(grp[k].d));
      chk($sformatf("clr_reg[%0d]", k), 32'(clr_reg[k]), 32'(grp[k].r));
      chk($sformatf("clr_tag[%0d]", k), 32'(clr_tag[k]), 32'(grp[k].t));
    end
    chk("occupancy", 32'(occupancy), 32'(m_occ));
  endtask

  initial begin
    logic [2:0] coal_wr_exp;
`ifdef RETIRE_WR_COALESCE_EN
    coal_wr_exp = 3'b110;
`else
    coal_wr_exp = 3'b111;
`endif
    rst_n = 1'b0; enq_valid = '0; wr_stall = 1'b0; flush = 1'b0;
    enq_reg = '0; enq_data = '0; enq_tag = '0;
    #3;
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_clr_en", 32'(clr_en), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_clr_tag", 32'(clr_tag), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Single retire, 1-cycle latency.
    set_slot(0, 4'd3, 16'hBEEF, 4'd7);
    tick(0, 0, 3'b001);
    tick(0, 0, 3'b000);
    chk("single_wr_en", 32'(wr_en), 32'h1);
    chk("single_wr_data", 32'(wr_data[0]), 32'hBEEF);
    chk("single_clr_tag", 32'(clr_tag[0]), 32'd7);

    // Backpressure: 6 queued under stall, enq_ready drops, then ordered drain.
    fill_slots(16'h10); tick(1, 0, 3'b111);
    fill_slots(16'h20); tick(1, 0, 3'b111);
    chk("full_occ", 32'(occupancy), 32'd6);
    chk("full_ready", 32'(enq_ready), 32'd0);
    fill_slots(16'h30); tick(1, 0, 3'b111);   // rejected, not ready
    tick(0, 0, 3'b000);
    chk("bp_ready_back", 32'(enq_ready), 32'd1);
    tick(0, 0, 3'b000);

    // Walk head to 6 (head=7 here), then packed 3'b101 and a wrapping drain group.
    fill_slots(16'h40); tick(1, 0, 3'b111);
    fill_slots(16'h50); tick(1, 0, 3'b111);
    tick(0, 0, 3'b000);
    fill_slots(16'h60); tick(0, 0, 3'b001);
    tick(0, 0, 3'b000);
    fill_slots(16'h70); tick(1, 0, 3'b101);
    fill_slots(16'h80); tick(1, 0, 3'b011);
    tick(0, 0, 3'b000);
    tick(0, 0, 3'b000);

    // Flush with 4 queued plus 3 incoming.
    fill_slots(16'h90); tick(1, 0, 3'b111);
    fill_slots(16'hA0); tick(1, 0, 3'b001);
    fill_slots(16'hB0); tick(0, 1, 3'b111);
    chk("flush_occ", 32'(occupancy), 32'd0);
    tick(0, 0, 3'b000);
    tick(0, 0, 3'b000);

    // Same-target drain group {5,2,5}.
    set_slot(0, 4'd5, 16'h0C01, 4'd1);
    set_slot(1, 4'd2, 16'h0C02, 4'd2);
    set_slot(2, 4'd5, 16'h0C03, 4'd3);
    tick(1, 0, 3'b111);
    tick(0, 0, 3'b000);
    chk("coal_wr_en", 32'(wr_en), 32'(coal_wr_exp));
    chk("coal_clr_en", 32'(clr_en), 32'h7);

    // Short random run, small register range to provoke collisions.
    for (int i = 0; i < 40; i++) begin
      for (int s = 0; s < 3; s++)
        set_slot(s, 4'($urandom_range(0, 3)), 16'($urandom), 4'($urandom));
      tick(($urandom_range(0, 3) == 0), 1'b0, 3'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 3'b000);

    // Reset in the middle of a drain.
    fill_slots(16'hD0); tick(1, 0, 3'b111);
    fill_slots(16'hE0); tick(1, 0, 3'b011);
    tick(0, 0, 3'b000);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_occ", 32'(occupancy), 32'd0);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_clr_en", 32'(clr_en), 32'd0);
    sb.delete();
    m_occ = 0;
    @(negedge clk) rst_n = 1'b1;
    tick(0, 0, 3'b000);
    tick(0, 0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/retire_write_scheduler.md
Name: retire_write_scheduler

Overview:
- Sits between the reorder-buffer retirement logic and the 3-port architectural register file write interface.
- Buffers retired results in an in-order circular queue and drains up to 3 per cycle onto registered write ports.
- Per port, emits a busy-clear request tagged with the retiring ROB tag, so the register file releases a register only when the owner still matches.
- Handles backpressure, stall and flush.

Parameters:
DEPTH, 8, queue entries; power of 2, >= 4
DATA_W, 16, result width
REG_W, 4, architectural register index width
TAG_W, 4, ROB tag / owner width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
enq_valid  in  3  per-slot retirement valid; slot 0 oldest
enq_reg  in  3xREG_W  target register per slot
enq_data  in  3xDATA_W  result value per slot
enq_tag  in  3xTAG_W  ROB tag per slot
enq_ready  out  1  queue can accept 3 entries this cycle
wr_stall  in  1  register file cannot accept writes this cycle
flush  in  1  discard all queued and incoming entries
wr_en  out  3  write enable per port
wr_reg  out  3xREG_W  write target per port
wr_data  out  3xDATA_W  write value per port
clr_en  out  3  busy-clear request per port
clr_reg  out  3xREG_W  register to clear
clr_tag  out  3xTAG_W  tag to compare against owner
occupancy  out  $clog2(DEPTH)+1  entries currently queued

Behaviour:
- Reset (async, rst_n=0): head=tail=0, occupancy=0; wr_en/clr_en=0; wr_reg/wr_data/clr_reg/clr_tag=0. Reset mid-drain drops everything immediately, with no partial writes.
- enq_ready is combinational: (DEPTH - occupancy) >= 3. It ignores same-cycle drains.
- Enqueue fires when enq_ready=1 and any enq_valid bit is set.
  - Valid slots are packed in slot order at tail; tail advances by popcount(enq_valid).
  - Non-contiguous patterns are legal; e.g. 3'b101 writes slot0, then slot2.
  - enq_valid with enq_ready=0: entries are not accepted, and the producer must hold them.
- Drain: each cycle with wr_stall=0 and flush=0, n = min(3, occupancy) oldest entries leave.
  - Entry head+k drives port k.
  - Outputs are registered: an entry enqueued at edge N reaches the ports at edge N+1 at earliest (queue empty, no stall), i.e. 1-cycle latency.
- Port k unused or stall: wr_en[k]=0 and clr_en[k]=0. Data and reg fields hold their last value and are don't-care.
- clr_en[k] equals wr_en[k] before coalescing (see Optional Feature). clr_* fields come from the same entry.
- Simultaneous enqueue and drain: occupancy_next = occupancy + enq_count - n. Pointers wrap modulo DEPTH.
- Empty: no drain, all enables 0. Full (occupancy=DEPTH): enq_ready=0, and drain proceeds normally.
- wr_stall=1: queue frozen; enqueue still allowed if enq_ready; enables 0 next cycle.
- flush=1 (synchronous, highest priority):
  - head=tail=0, occupancy=0.
  - Same-cycle enqueue is dropped.
  - All enables 0 at the next edge.
  - Writes already registered on the ports in the flush cycle complete.

Optional Feature:
Macro RETIRE_WR_COALESCE_EN.
- Defined: within one drain group, if an older port's wr_reg equals a younger port's wr_reg, the older wr_en is forced to 0; only the youngest write issues. clr_en for all ports is unaffected, and every tag is still offered for clearing.
- Undefined: all drained entries assert wr_en. The register file resolves same-target collisions by higher port index winning.

Test Plan:
- Reset mid-drain: queue 5 entries, pull rst_n low mid-cycle -> occupancy=0 and wr_en=3'b000 immediately; nothing written after release.
- Single retire: enq_valid=3'b001, reg=4'd3, data=16'hBEEF, tag=4'd7 at edge N -> at edge N+1 wr_en=3'b001, wr_reg[0]=3, wr_data[0]=16'hBEEF, clr_tag[0]=7; occupancy back to 0.
- Full/backpressure (DEPTH=8): enqueue 3+3 with wr_stall=1 -> occupancy=6 and enq_ready=0. Release stall -> ports drain entries 0-2 then 3-5 over 2 cycles in order, and enq_ready reasserts once occupancy<=5.
- Packing and wrap: drive head=6, then enq_valid=3'b101 -> entries land at indices 6 and 7, next enqueue at index 0; drain order is preserved across the wrap.
- Flush: 4 queued plus enq_valid=3'b111 with flush=1 -> occupancy=0 next cycle, no wr_en for any of the 7 entries.
- Coalesce: drain group with regs {5,2,5} -> with RETIRE_WR_COALESCE_EN, wr_en=3'b110 and clr_en=3'b111; without it, wr_en=3'b111.
